// File: rtl/circuito_jogo_rodadas.sv
// Sequence-memory game core: LFSR-generated sequence, progressive rounds, one play per rising press.
// Optional inactivity timeout is compiled in with JOGO_TIMEOUT_EN.
module circuito_jogo_rodadas #(
    parameter int          NBOTOES        = 4,
    parameter int          PROFUNDIDADE   = 16,
    parameter int          TIMEOUT_CICLOS = 5000,
    parameter logic [15:0] SEMENTE        = 16'h0001,
    localparam int         W              = $clog2(NBOTOES),
    localparam int         D              = $clog2(PROFUNDIDADE)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [NBOTOES-1:0] botoes,
    output logic [NBOTOES-1:0] leds,
    output logic               pronto,
    output logic               acertou,
    output logic               errou,
    output logic               timeout,
    output logic [3:0]         db_estado,
    output logic [D-1:0]       db_rodada,
    output logic [D-1:0]       db_contagem,
    output logic [NBOTOES-1:0] db_jogada,
    output logic [NBOTOES-1:0] db_esperado
);

    typedef enum logic [3:0] {
        inicial        = 4'd0,
        preparacao     = 4'd1,
        inicio_rodada  = 4'd2,
        espera_jogada  = 4'd3,
        registra       = 4'd4,
        compara        = 4'd5,
        proxima_jogada = 4'd6,
        proxima_rodada = 4'd7,
        fim_acerto     = 4'd10,
        fim_timeout    = 4'd13,
        fim_erro       = 4'd14
    } estado_t;

    estado_t            estado;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_prox;
    logic [W-1:0]       mem [PROFUNDIDADE];
    logic [D-1:0]       indice;
    logic [D-1:0]       rodada;
    logic [D-1:0]       contagem;
    logic [NBOTOES-1:0] botoes_q;
    logic [NBOTOES-1:0] esperado;
    logic               evento;

`ifdef JOGO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    logic [TW-1:0] tempo;
`endif

    always_comb begin
        lfsr_prox = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        // A play is a press starting from all-released; holding a button never repeats it.
        evento    = (botoes != '0) && (botoes_q == '0);
        esperado  = '0;
        esperado[mem[contagem]] = 1'b1;
    end

    assign leds        = botoes;
    assign db_estado   = estado;
    assign db_rodada   = rodada;
    assign db_contagem = contagem;
    assign db_esperado = esperado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado    <= inicial;
            lfsr      <= SEMENTE;
            mem       <= '{default: '0};
            indice    <= '0;
            rodada    <= '0;
            contagem  <= '0;
            botoes_q  <= '0;
            db_jogada <= '0;
            pronto    <= 1'b0;
            acertou   <= 1'b0;
            errou     <= 1'b0;
            timeout   <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
            tempo     <= '0;
`endif
        end else begin
            botoes_q <= botoes;
            unique case (estado)
                inicial: begin
                    if (iniciar) begin
                        indice <= '0;
                        estado <= preparacao;
                    end
                end
                preparacao: begin
                    mem[indice] <= lfsr[W-1:0];
                    lfsr        <= lfsr_prox;
                    rodada      <= '0;
                    pronto      <= 1'b0;
                    acertou     <= 1'b0;
                    errou       <= 1'b0;
                    timeout     <= 1'b0;
                    if (indice == D'(PROFUNDIDADE - 1)) begin
                        estado <= inicio_rodada;
                    end else begin
                        indice <= indice + D'(1);
                    end
                end
                inicio_rodada: begin
                    contagem <= '0;
`ifdef JOGO_TIMEOUT_EN
                    tempo    <= '0;
`endif
                    estado   <= espera_jogada;
                end
                espera_jogada: begin
                    if (evento) begin
                        estado <= registra;
`ifdef JOGO_TIMEOUT_EN
                    end else if (tempo == TW'(TIMEOUT_CICLOS - 1)) begin
                        pronto  <= 1'b1;
                        errou   <= 1'b1;
                        timeout <= 1'b1;
                        estado  <= fim_timeout;
                    end else begin
                        tempo <= tempo + TW'(1);
`endif
                    end
                end
                registra: begin
                    db_jogada <= botoes;
`ifdef JOGO_TIMEOUT_EN
                    tempo     <= '0;
`endif
                    estado    <= compara;
                end
                compara: begin
                    if (db_jogada != esperado) begin
                        pronto <= 1'b1;
                        errou  <= 1'b1;
                        estado <= fim_erro;
                    end else if (contagem < rodada) begin
                        estado <= proxima_jogada;
                    end else if (rodada == D'(PROFUNDIDADE - 1)) begin
                        pronto  <= 1'b1;
                        acertou <= 1'b1;
                        estado  <= fim_acerto;
                    end else begin
                        estado <= proxima_rodada;
                    end
                end
                proxima_jogada: begin
                    contagem <= contagem + D'(1);
                    estado   <= espera_jogada;
                end
                proxima_rodada: begin
                    rodada <= rodada + D'(1);
                    estado <= inicio_rodada;
                end
                fim_acerto, fim_erro, fim_timeout: begin
                    if (iniciar) begin
                        indice <= '0;
                        estado <= preparacao;
                    end
                end
                default: estado <= inicial;
            endcase
        end
    end

endmodule

// File: tb/tb_circuito_jogo_rodadas.sv
// Randomized bench for circuito_jogo_rodadas against a round/sequence model built from the game rules.
module tb_circuito_jogo_rodadas;

    localparam int NB   = 4;
    localparam int PROF = 16;
    localparam int TOUT = 20;
`ifdef JOGO_TIMEOUT_EN
    localparam int OCIOSO_MAX = 19;
    localparam int SEGURA     = 8;
`else
    localparam int OCIOSO_MAX = 30;
    localparam int SEGURA     = 46;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic [NB-1:0] botoes;
    logic [NB-1:0] leds;
    logic          pronto, acertou, errou, timeout;
    logic [3:0]    db_estado;
    logic [3:0]    db_rodada, db_contagem;
    logic [NB-1:0] db_jogada, db_esperado;

    circuito_jogo_rodadas #(
        .NBOTOES(NB), .PROFUNDIDADE(PROF), .TIMEOUT_CICLOS(TOUT), .SEMENTE(16'h0001)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes), .leds(leds),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado), .db_rodada(db_rodada), .db_contagem(db_contagem),
        .db_jogada(db_jogada), .db_esperado(db_esperado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: sequence values and game position
    int m_lfsr;
    int m_seq [PROF];
    int m_rod, m_cont;
    bit m_fim;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_avanca(input int q);
        int fb;
        fb = ((q >> 15) ^ (q >> 13) ^ (q >> 12) ^ (q >> 10)) & 1;
        return ((q << 1) & 16'hffff) | fb;
    endfunction

    function automatic int um_quente(input int v);
        return 1 << v;
    endfunction

    function automatic int correta();
        return um_quente(m_seq[m_cont]);
    endfunction

    function automatic logic [NB-1:0] errada(input int certo);
        logic [NB-1:0] v;
        do v = NB'($urandom_range(1, (1 << NB) - 1)); while (int'(v) == certo);
        return v;
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_flags(input string tag, input int p, input int a, input int e, input int t);
        check({tag, "_pronto"}, pronto, p);
        check({tag, "_acertou"}, acertou, a);
        check({tag, "_errou"}, errou, e);
        check({tag, "_timeout"}, timeout, t);
    endtask

    task automatic inicia_jogo();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("estado_preparacao", db_estado, 1);
        for (int i = 0; i < PROF; i++) begin
            m_seq[i] = m_lfsr % NB;
            m_lfsr   = lfsr_avanca(m_lfsr);
        end
        tick();
        check_flags("prep", 0, 0, 0, 0);
        check("prep_rodada", db_rodada, 0);
        repeat (PROF) tick();
        check("inicio_espera", db_estado, 3);
        check("inicio_rodada0", db_rodada, 0);
        m_rod  = 0;
        m_cont = 0;
        m_fim  = 0;
    endtask

    task automatic jogar(input logic [NB-1:0] b, input int ocioso, input int segura);
        int res;
        check("esperado", db_esperado, correta());
        check("contagem", db_contagem, m_cont);
        repeat (ocioso) tick();
        botoes = b;
        tick();
        check("estado_registra", db_estado, 4);
        tick();
        check("estado_compara", db_estado, 5);
        if (segura == 0) botoes = '0;
        if (int'(b) != correta()) res = 14;
        else if (m_cont < m_rod) res = 6;
        else if (m_rod == PROF - 1) res = 10;
        else res = 7;
        tick();
        check("estado_pos_compara", db_estado, res);
        check("db_jogada", db_jogada, b);
        case (res)
            6: begin
                m_cont++;
                tick();
                check("volta_espera", db_estado, 3);
                check("contagem_inc", db_contagem, m_cont);
            end
            7: begin
                m_rod++;
                m_cont = 0;
                tick();
                check("estado_inicio_rodada", db_estado, 2);
                check("rodada_inc", db_rodada, m_rod);
                tick();
                check("nova_espera", db_estado, 3);
            end
            10: begin
                check_flags("acerto", 1, 1, 0, 0);
                m_fim = 1;
            end
            default: begin
                check_flags("erro", 1, 0, 1, 0);
                m_fim = 1;
            end
        endcase
        if (segura > 0) begin
            repeat (segura) tick();
            check("segura_estado", db_estado, 3);
            check("segura_contagem", db_contagem, m_cont);
            botoes = '0;
            tick();
        end
    endtask

    task automatic joga_rodada_certa();
        int r;
        r = m_rod;
        while (!m_fim && m_rod == r) jogar(NB'(correta()), $urandom_range(0, OCIOSO_MAX), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] v;
        reset   = 1'b0;
        iniciar = 1'b0;
        botoes  = '0;
        m_lfsr  = 1;
        repeat (3) tick();
        check("reset_estado", db_estado, 0);
        check_flags("reset", 0, 0, 0, 0);
        check("reset_rodada", db_rodada, 0);
        check("reset_contagem", db_contagem, 0);
        check("reset_jogada", db_jogada, 0);
        v = NB'($urandom_range(1, 15));
        botoes = v;
        #1 check("leds", leds, v);
        botoes = '0;
        tick();
        reset = 1'b1;
        tick();
        check("inicial_parado", db_estado, 0);

        // Game 1: first sequence, two rounds correct, then a wrong play
        inicia_jogo();
        check("seq0_semente", db_esperado, 4'b0010);
        joga_rodada_certa();
        check("rodada1", db_rodada, 1);
        joga_rodada_certa();
        check("rodada2", db_rodada, 2);
        check("rodada2_errou", errou, 0);
        jogar(errada(correta()), 0, 0);
        repeat (100) tick();
        check("fim_erro_mantem", db_estado, 14);
        check_flags("fim_erro_mantem", 1, 0, 1, 0);

        // Game 2: restart, ignored iniciar, held button, multi-button press
        inicia_jogo();
        joga_rodada_certa();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        check("iniciar_ignorado", db_estado, 3);
        jogar(NB'(correta()), 0, SEGURA);
        jogar(NB'(correta()), 0, 0);
        check("apos_segura_rodada", db_rodada, 2);
        v = NB'(correta());
        v = v | ((v == 4'b0001) ? 4'b0010 : 4'b0001);
        jogar(v, $urandom_range(0, OCIOSO_MAX), 0);
        check("multi_estado", db_estado, 14);

`ifdef JOGO_TIMEOUT_EN
        // Game 3: inactivity
        inicia_jogo();
        repeat (TOUT - 1) tick();
        check("antes_timeout", db_estado, 3);
        tick();
        check("fim_timeout", db_estado, 13);
        check_flags("timeout", 1, 0, 1, 1);
        m_fim = 1;
`else
        inicia_jogo();
        repeat (100) tick();
        check("sem_timeout", db_estado, 3);
        check("sem_timeout_flag", timeout, 0);
        jogar(errada(correta()), 0, 0);
`endif

        // Game 4: press on the last idle cycle, then a complete correct game
        inicia_jogo();
        repeat (TOUT - 1) tick();
        jogar(NB'(correta()), 0, 0);
        while (!m_fim) jogar(NB'(correta()), $urandom_range(0, OCIOSO_MAX), 0);
        check("jogo_completo_estado", db_estado, 10);
        check_flags("jogo_completo", 1, 1, 0, 0);

        // Random games with occasional wrong plays
        for (int g = 0; g < 3; g++) begin
            inicia_jogo();
            while (!m_fim) begin
                if ($urandom_range(0, 24) == 0) jogar(errada(correta()), $urandom_range(0, OCIOSO_MAX), 0);
                else jogar(NB'(correta()), $urandom_range(0, OCIOSO_MAX), 0);
            end
        end

        // Asynchronous reset mid-round, then the sequence restarts from the seed
        inicia_jogo();
        joga_rodada_certa();
        jogar(NB'(correta()), 0, 0);
        #2 reset = 1'b0;
        #1;
        check("areset_estado", db_estado, 0);
        check_flags("areset", 0, 0, 0, 0);
        check("areset_rodada", db_rodada, 0);
        check("areset_contagem", db_contagem, 0);
        check("areset_jogada", db_jogada, 0);
        m_lfsr = 1;
        tick();
        reset = 1'b1;
        tick();
        inicia_jogo();
        check("seq0_apos_reset", db_esperado, 4'b0010);
        joga_rodada_certa();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
